// File: rtl/rank_filter_3x3.sv
// -----------------------------------------------------------------------------
// rank_filter_3x3
//   3x3 rank-order filter with selectable median / min / max / centre bypass.
//   The window is registered on input. Three compute stages follow:
//     stage 1 : sort each row into max / mid / min
//     stage 2 : max-of-mins, mid-of-mids, min-of-maxes (median candidates),
//               plus min-of-mins and max-of-maxes (window extremes)
//     stage 3 : median of the three candidates and selection by mode
//   A window sampled on edge N appears on target_data with out_valid after
//   edge N+3. Valid tag, mode, centre pixel and sync sidebands travel with it.
//   A new window can be accepted every cycle. There is no stall.
//
// Optional build macro: RANK_FILTER_ADAPTIVE_EN
//   When it is defined, median mode is impulse-adaptive. The output is the
//   median only when the centre pixel equals the window min or max. Otherwise
//   the output is the centre pixel. The macro does not change latency.
//
// Ports
//   clk                 : rising-edge clock
//   rst_n               : synchronous active-low reset
//   data11..data33      : 3x3 window, row-major; data22 is the centre pixel
//   in_valid            : window valid this cycle
//   mode                : 00 median, 01 min, 10 max, 11 centre bypass
//   in_hsync, in_vsync  : sync sidebands, delayed unconditionally
//   target_data         : filtered pixel; holds its value while out_valid=0
//   out_valid           : target_data valid
//   out_hsync, out_vsync: sidebands delayed to match target_data
// -----------------------------------------------------------------------------
module rank_filter_3x3 #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data11,
  input  logic [DATA_W-1:0] data12,
  input  logic [DATA_W-1:0] data13,
  input  logic [DATA_W-1:0] data21,
  input  logic [DATA_W-1:0] data22,
  input  logic [DATA_W-1:0] data23,
  input  logic [DATA_W-1:0] data31,
  input  logic [DATA_W-1:0] data32,
  input  logic [DATA_W-1:0] data33,
  input  logic              in_valid,
  input  logic [1:0]        mode,
  input  logic              in_hsync,
  input  logic              in_vsync,
  output logic [DATA_W-1:0] target_data,
  output logic              out_valid,
  output logic              out_hsync,
  output logic              out_vsync
);

  typedef enum logic [1:0] {
    MODE_MEDIAN = 2'b00,
    MODE_MIN    = 2'b01,
    MODE_MAX    = 2'b10,
    MODE_BYPASS = 2'b11
  } mode_t;

  // ---------------------------------------------------------------------------
  // Unsigned compare helpers
  // ---------------------------------------------------------------------------
  function automatic logic [DATA_W-1:0] max2(input logic [DATA_W-1:0] a,
                                             input logic [DATA_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [DATA_W-1:0] min2(input logic [DATA_W-1:0] a,
                                             input logic [DATA_W-1:0] b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [DATA_W-1:0] max3(input logic [DATA_W-1:0] a,
                                             input logic [DATA_W-1:0] b,
                                             input logic [DATA_W-1:0] c);
    return max2(max2(a, b), c);
  endfunction

  function automatic logic [DATA_W-1:0] min3(input logic [DATA_W-1:0] a,
                                             input logic [DATA_W-1:0] b,
                                             input logic [DATA_W-1:0] c);
    return min2(min2(a, b), c);
  endfunction

  // Middle of three: the larger of min(a,b) and min(max(a,b),c)
  function automatic logic [DATA_W-1:0] mid3(input logic [DATA_W-1:0] a,
                                             input logic [DATA_W-1:0] b,
                                             input logic [DATA_W-1:0] c);
    return max2(min2(a, b), min2(max2(a, b), c));
  endfunction

  // ---------------------------------------------------------------------------
  // Input capture
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] w_in [9];
  logic [DATA_W-1:0] r0_win [9];
  logic              r0_valid;
  mode_t             r0_mode;
  logic              r0_hs;
  logic              r0_vs;

  always_comb begin
    w_in[0] = data11;
    w_in[1] = data12;
    w_in[2] = data13;
    w_in[3] = data21;
    w_in[4] = data22;
    w_in[5] = data23;
    w_in[6] = data31;
    w_in[7] = data32;
    w_in[8] = data33;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r0_valid <= 1'b0;
      r0_mode  <= MODE_MEDIAN;
      r0_hs    <= 1'b0;
      r0_vs    <= 1'b0;
    end else begin
      r0_valid <= in_valid;
      r0_mode  <= mode_t'(mode);
      r0_hs    <= in_hsync;
      r0_vs    <= in_vsync;
      for (int unsigned i = 0; i < 9; i++) begin
        r0_win[i] <= w_in[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1: per-row sort
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] w_row_max [3];
  logic [DATA_W-1:0] w_row_mid [3];
  logic [DATA_W-1:0] w_row_min [3];
  logic [DATA_W-1:0] r1_max [3];
  logic [DATA_W-1:0] r1_mid [3];
  logic [DATA_W-1:0] r1_min [3];
  logic [DATA_W-1:0] r1_centre;
  logic              r1_valid;
  mode_t             r1_mode;
  logic              r1_hs;
  logic              r1_vs;

  always_comb begin
    for (int unsigned r = 0; r < 3; r++) begin
      w_row_max[r] = max3(r0_win[3*r], r0_win[3*r+1], r0_win[3*r+2]);
      w_row_mid[r] = mid3(r0_win[3*r], r0_win[3*r+1], r0_win[3*r+2]);
      w_row_min[r] = min3(r0_win[3*r], r0_win[3*r+1], r0_win[3*r+2]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r1_valid <= 1'b0;
      r1_mode  <= MODE_MEDIAN;
      r1_hs    <= 1'b0;
      r1_vs    <= 1'b0;
    end else begin
      r1_valid  <= r0_valid;
      r1_mode   <= r0_mode;
      r1_hs     <= r0_hs;
      r1_vs     <= r0_vs;
      r1_centre <= r0_win[4];
      for (int unsigned r = 0; r < 3; r++) begin
        r1_max[r] <= w_row_max[r];
        r1_mid[r] <= w_row_mid[r];
        r1_min[r] <= w_row_min[r];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: median candidates and window extremes
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] r2_max_of_mins;
  logic [DATA_W-1:0] r2_mid_of_mids;
  logic [DATA_W-1:0] r2_min_of_maxes;
  logic [DATA_W-1:0] r2_min_of_mins;
  logic [DATA_W-1:0] r2_max_of_maxes;
  logic [DATA_W-1:0] r2_centre;
  logic              r2_valid;
  mode_t             r2_mode;
  logic              r2_hs;
  logic              r2_vs;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r2_valid <= 1'b0;
      r2_mode  <= MODE_MEDIAN;
      r2_hs    <= 1'b0;
      r2_vs    <= 1'b0;
    end else begin
      r2_valid        <= r1_valid;
      r2_mode         <= r1_mode;
      r2_hs           <= r1_hs;
      r2_vs           <= r1_vs;
      r2_centre       <= r1_centre;
      r2_max_of_mins  <= max3(r1_min[0], r1_min[1], r1_min[2]);
      r2_mid_of_mids  <= mid3(r1_mid[0], r1_mid[1], r1_mid[2]);
      r2_min_of_maxes <= min3(r1_max[0], r1_max[1], r1_max[2]);
      r2_min_of_mins  <= min3(r1_min[0], r1_min[1], r1_min[2]);
      r2_max_of_maxes <= max3(r1_max[0], r1_max[1], r1_max[2]);
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 3: final median and output selection
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] w_median;
  logic [DATA_W-1:0] w_med_out;
  logic [DATA_W-1:0] w_sel;

  assign w_median = mid3(r2_max_of_mins, r2_mid_of_mids, r2_min_of_maxes);

`ifdef RANK_FILTER_ADAPTIVE_EN
  // Treat the centre as an impulse only when it is a window extreme.
  // Otherwise keep the centre so that detail is preserved.
  logic w_centre_extreme;
  assign w_centre_extreme = (r2_centre == r2_min_of_mins) ||
                            (r2_centre == r2_max_of_maxes);
  assign w_med_out = w_centre_extreme ? w_median : r2_centre;
`else
  assign w_med_out = w_median;
`endif

  always_comb begin
    w_sel = w_med_out;
    case (r2_mode)
      MODE_MEDIAN: w_sel = w_med_out;
      MODE_MIN:    w_sel = r2_min_of_mins;
      MODE_MAX:    w_sel = r2_max_of_maxes;
      MODE_BYPASS: w_sel = r2_centre;
      default:     w_sel = w_med_out;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      target_data <= '0;
      out_valid   <= 1'b0;
      out_hsync   <= 1'b0;
      out_vsync   <= 1'b0;
    end else begin
      out_valid <= r2_valid;
      out_hsync <= r2_hs;
      out_vsync <= r2_vs;
      if (r2_valid) begin
        target_data <= w_sel;
      end
    end
  end

endmodule

// File: tb/tb_rank_filter_3x3.sv
module tb_rank_filter_3x3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // ---------------- instance A: DATA_W = 8, model checked ----------------
  logic       a_rst_n;
  logic [7:0] a_d [9];
  logic       a_valid;
  logic [1:0] a_mode;
  logic       a_hs, a_vs;
  logic [7:0] a_td;
  logic       a_ov, a_ohs, a_ovs;

  rank_filter_3x3 #(.DATA_W(8)) u_a (
    .clk(clk), .rst_n(a_rst_n),
    .data11(a_d[0]), .data12(a_d[1]), .data13(a_d[2]),
    .data21(a_d[3]), .data22(a_d[4]), .data23(a_d[5]),
    .data31(a_d[6]), .data32(a_d[7]), .data33(a_d[8]),
    .in_valid(a_valid), .mode(a_mode), .in_hsync(a_hs), .in_vsync(a_vs),
    .target_data(a_td), .out_valid(a_ov), .out_hsync(a_ohs), .out_vsync(a_ovs)
  );

  // ---------------- instance B: DATA_W = 10, directed ----------------
  logic       b_rst_n;
  logic [9:0] b_d [9];
  logic       b_valid;
  logic [1:0] b_mode;
  logic       b_hs;
  logic [9:0] b_td;
  logic       b_ov, b_ohs, b_ovs;

  rank_filter_3x3 #(.DATA_W(10)) u_b (
    .clk(clk), .rst_n(b_rst_n),
    .data11(b_d[0]), .data12(b_d[1]), .data13(b_d[2]),
    .data21(b_d[3]), .data22(b_d[4]), .data23(b_d[5]),
    .data31(b_d[6]), .data32(b_d[7]), .data33(b_d[8]),
    .in_valid(b_valid), .mode(b_mode), .in_hsync(b_hs), .in_vsync(b_hs),
    .target_data(b_td), .out_valid(b_ov), .out_hsync(b_ohs), .out_vsync(b_ovs)
  );

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: sort all nine values and pick by rank (8-bit window, data11 in MSBs)
  function automatic int unsigned ref_out(input logic [71:0] w, input logic [1:0] m);
    int unsigned s [9];
    int unsigned c, t, med;
    for (int i = 0; i < 9; i++) s[i] = w[71-8*i -: 8];
    c = s[4];
    for (int i = 1; i < 9; i++)
      for (int j = i; j > 0; j--)
        if (s[j-1] > s[j]) begin t = s[j]; s[j] = s[j-1]; s[j-1] = t; end
    med = s[4];
`ifdef RANK_FILTER_ADAPTIVE_EN
    if (!(c == s[0] || c == s[8])) med = c;
`endif
    case (m)
      2'd0: return med;
      2'd1: return s[0];
      2'd2: return s[8];
      default: return c;
    endcase
  endfunction

  // ---------------- behavioural model for instance A ----------------
  localparam int NREC = 8192;
  logic        rec_v [NREC];
  int unsigned rec_d [NREC];
  logic        rec_h [NREC];
  logic        rec_s [NREC];
  logic        exp_v = 1'b0, exp_h = 1'b0, exp_s = 1'b0;
  int unsigned exp_td = 0;
  logic        model_ready = 1'b0;

  initial begin
    int k;
    logic [71:0] w;
    k = 0;
    forever begin
      @(posedge clk);
      if (k < NREC) begin
        for (int i = 0; i < 9; i++) w[71-8*i -: 8] = a_d[i];
        if (!a_rst_n) begin
          // reset kills this window and every window still in flight
          rec_v[k] = 1'b0; rec_d[k] = 0; rec_h[k] = 1'b0; rec_s[k] = 1'b0;
          for (int j = k - 3; j < k; j++)
            if (j >= 0) begin rec_v[j] = 1'b0; rec_h[j] = 1'b0; rec_s[j] = 1'b0; end
        end else begin
          rec_v[k] = a_valid; rec_d[k] = ref_out(w, a_mode);
          rec_h[k] = a_hs;    rec_s[k] = a_vs;
        end
        if (k >= 3) begin
          exp_v = rec_v[k-3]; exp_h = rec_h[k-3]; exp_s = rec_s[k-3];
        end else begin
          exp_v = 1'b0; exp_h = 1'b0; exp_s = 1'b0;
        end
        if (!a_rst_n) exp_td = 0;
        else if (exp_v) exp_td = rec_d[k-3];
        k++;
        model_ready = 1'b1;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (model_ready) begin
        chk("model_out_valid", a_ov, exp_v);
        chk("model_out_hsync", a_ohs, exp_h);
        chk("model_out_vsync", a_ovs, exp_s);
        chk("model_target_data", a_td, exp_td);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input logic r, input logic [71:0] w, input logic v,
                      input logic [1:0] m, input logic hs, input logic vs);
    @(negedge clk);
    a_rst_n = r;
    for (int i = 0; i < 9; i++) a_d[i] = w[71-8*i -: 8];
    a_valid = v; a_mode = m; a_hs = hs; a_vs = vs;
  endtask

  task automatic btick(input logic r, input logic [89:0] w, input logic v,
                       input logic [1:0] m, input logic hs);
    @(negedge clk);
    b_rst_n = r;
    for (int i = 0; i < 9; i++) b_d[i] = w[89-10*i -: 10];
    b_valid = v; b_mode = m; b_hs = hs;
  endtask

  task automatic b_all_zero(input string name);
    chk({name, "_ov"}, b_ov, 0);
    chk({name, "_td"}, b_td, 0);
    chk({name, "_hs"}, b_ohs, 0);
    chk({name, "_vs"}, b_ovs, 0);
  endtask

  logic [71:0] W1, W31, W32, WZ, wr;
  logic [89:0] WB1, WB2, WBZ;
  int unsigned exp32;

  initial begin
    W1  = {8'd9, 8'd1, 8'd8, 8'd2, 8'd7, 8'd3, 8'd6, 8'd4, 8'd5};
    W31 = {8'd200, 8'd200, 8'd200, 8'd200, 8'd0, 8'd200, 8'd200, 8'd200, 8'd200};
    W32 = {8'd10, 8'd50, 8'd90, 8'd20, 8'd40, 8'd80, 8'd30, 8'd60, 8'd70};
    WZ  = '0;
    WB1 = {10'd0, {8{10'd1023}}};
    WB2 = {{8{10'd1023}}, 10'd0};
    WBZ = '0;
`ifdef RANK_FILTER_ADAPTIVE_EN
    exp32 = 40;
`else
    exp32 = 50;
`endif

    a_rst_n = 1'b0; a_valid = 1'b0; a_mode = 2'd0; a_hs = 1'b0; a_vs = 1'b0;
    for (int i = 0; i < 9; i++) a_d[i] = '0;
    b_rst_n = 1'b0; b_valid = 1'b0; b_mode = 2'd0; b_hs = 1'b0;
    for (int i = 0; i < 9; i++) b_d[i] = '0;

    // reset, with in_valid high to show it is ignored under reset
    tick(1'b0, W1, 1'b1, 2'd0, 1'b1, 1'b1);
    tick(1'b0, W1, 1'b1, 2'd0, 1'b1, 1'b1);
    tick(1'b0, WZ, 1'b0, 2'd0, 1'b0, 1'b0);
    @(negedge clk) b_rst_n = 1'b1;
    tick(1'b1, WZ, 1'b0, 2'd0, 1'b0, 1'b0);
    chk("reset_td", a_td, 0);
    chk("reset_ov", a_ov, 0);
    chk("reset_hs", a_ohs, 0);
    chk("reset_vs", a_ovs, 0);

    // single median window: 5 after three edges, valid for exactly one cycle
    tick(1'b1, W1, 1'b1, 2'd0, 1'b0, 1'b0);
    tick(1'b1, WZ, 1'b0, 2'd0, 1'b0, 1'b0);
    tick(1'b1, WZ, 1'b0, 2'd0, 1'b0, 1'b0);
    tick(1'b1, WZ, 1'b0, 2'd0, 1'b0, 1'b0);
    chk("median_early_ov", a_ov, 0);
    tick(1'b1, WZ, 1'b0, 2'd0, 1'b0, 1'b0);
    chk("median_ov", a_ov, 1);
    chk("median_td", a_td, 5);
    tick(1'b1, WZ, 1'b0, 2'd0, 1'b0, 1'b0);
    chk("median_ov_one_cycle", a_ov, 0);
    chk("median_td_held", a_td, 5);

    // min, max, bypass back to back
    tick(1'b1, W1, 1'b1, 2'd1, 1'b0, 1'b0);
    tick(1'b1, W1, 1'b1, 2'd2, 1'b0, 1'b0);
    tick(1'b1, W1, 1'b1, 2'd3, 1'b0, 1'b0);
    tick(1'b1, WZ, 1'b0, 2'd0, 1'b0, 1'b0);
    tick(1'b1, WZ, 1'b0, 2'd0, 1'b0, 1'b0);
    chk("min_td", a_td, 1);
    tick(1'b1, WZ, 1'b0, 2'd0, 1'b0, 1'b0);
    chk("max_td", a_td, 9);
    tick(1'b1, WZ, 1'b0, 2'd0, 1'b0, 1'b0);
    chk("bypass_td", a_td, 7);

    // impulse at the centre
    tick(1'b1, W31, 1'b1, 2'd0, 1'b0, 1'b0);
    repeat (3) tick(1'b1, WZ, 1'b0, 2'd0, 1'b0, 1'b0);
    tick(1'b1, WZ, 1'b0, 2'd0, 1'b0, 1'b0);
    chk("impulse_td", a_td, 200);

    // centre not extreme: adaptive build keeps the centre
    tick(1'b1, W32, 1'b1, 2'd0, 1'b0, 1'b0);
    repeat (3) tick(1'b1, WZ, 1'b0, 2'd0, 1'b0, 1'b0);
    tick(1'b1, WZ, 1'b0, 2'd0, 1'b0, 1'b0);
    chk("nonextreme_td", a_td, exp32);

    // valid 1,0,1 with hsync pulses
    tick(1'b1, W1,  1'b1, 2'd1, 1'b1, 1'b0);
    tick(1'b1, W32, 1'b0, 2'd2, 1'b0, 1'b0);
    tick(1'b1, W32, 1'b1, 2'd2, 1'b1, 1'b0);
    tick(1'b1, WZ,  1'b0, 2'd0, 1'b0, 1'b0);
    tick(1'b1, WZ,  1'b0, 2'd0, 1'b0, 1'b0);
    chk("bubble0_ov", a_ov, 1);
    chk("bubble0_hs", a_ohs, 1);
    chk("bubble0_td", a_td, 1);
    tick(1'b1, WZ,  1'b0, 2'd0, 1'b0, 1'b0);
    chk("bubble1_ov", a_ov, 0);
    chk("bubble1_hs", a_ohs, 0);
    chk("bubble1_td_held", a_td, 1);
    tick(1'b1, WZ,  1'b0, 2'd0, 1'b0, 1'b0);
    chk("bubble2_ov", a_ov, 1);
    chk("bubble2_hs", a_ohs, 1);
    chk("bubble2_td", a_td, 90);

    // randomized traffic with occasional mid-stream resets
    for (int n = 0; n < 3000; n++) begin
      logic dup;
      dup = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < 9; i++)
        wr[71-8*i -: 8] = dup ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255));
      tick(($urandom_range(0, 63) != 0), wr, ($urandom_range(0, 3) != 0),
           2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    tick(1'b1, WZ, 1'b0, 2'd0, 1'b0, 1'b0);

    // DATA_W = 10: two windows dropped by a one-cycle reset
    btick(1'b1, WB1, 1'b1, 2'd0, 1'b1);
    btick(1'b1, WB2, 1'b1, 2'd1, 1'b1);
    btick(1'b0, WB2, 1'b1, 2'd2, 1'b1);
    btick(1'b1, WBZ, 1'b0, 2'd0, 1'b0);
    b_all_zero("w10_rst_t3");
    btick(1'b1, WBZ, 1'b0, 2'd0, 1'b0);
    b_all_zero("w10_rst_t4");
    btick(1'b1, WBZ, 1'b0, 2'd0, 1'b0);
    b_all_zero("w10_rst_t5");
    btick(1'b1, WBZ, 1'b0, 2'd0, 1'b0);
    b_all_zero("w10_rst_t6");
    btick(1'b1, WB1, 1'b1, 2'd2, 1'b0);
    btick(1'b1, WBZ, 1'b0, 2'd0, 1'b0);
    btick(1'b1, WBZ, 1'b0, 2'd0, 1'b0);
    btick(1'b1, WBZ, 1'b0, 2'd0, 1'b0);
    chk("w10_post_early_ov", b_ov, 0);
    btick(1'b1, WBZ, 1'b0, 2'd0, 1'b0);
    chk("w10_post_ov", b_ov, 1);
    chk("w10_post_td", b_td, 1023);
    btick(1'b1, WBZ, 1'b0, 2'd0, 1'b0);
    chk("w10_post_ov_end", b_ov, 0);

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
